// File: rtl/rr_burst_mux.sv
// rr_burst_mux: round-robin arbiter front end that locks the winner for a whole burst
// and forwards its beats through a 1-deep registered output stage.
module rr_burst_mux #(
    parameter int nReq  = 4,
    parameter int W     = 32,
    parameter int SRC_W = $clog2(nReq)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [nReq-1:0]          in_valid,
    output logic [nReq-1:0]          in_ready,
    input  logic [nReq-1:0][W-1:0]   in_data,
    input  logic [nReq-1:0]          in_last,
    output logic [nReq-1:0]          arb_request,
    input  logic [nReq-1:0]          arb_grant,
    output logic                     arb_trigger,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_last,
    output logic [SRC_W-1:0]         out_src
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state;
    logic [SRC_W-1:0] lock_idx;
    logic [SRC_W-1:0] idx;
    logic [nReq-1:0]  acc;
    logic [nReq-1:0]  lock_vec;
    logic             space;
    logic             sel_last;
    logic [W-1:0]     sel_data;
    always_comb begin
        space       = !out_valid || out_ready;
        lock_vec    = nReq'(1) << lock_idx;
        in_ready    = (reset || !space) ? '0 : (state == IDLE) ? (arb_grant & in_valid) : lock_vec;
        acc         = in_valid & in_ready;
        arb_trigger = !reset && state == IDLE && |in_ready;
        arb_request = (state == IDLE) ? in_valid : '0;
        idx         = '0;
        for (int i = 0; i < nReq; i++)
            if (acc[i]) idx = SRC_W'(i);
        sel_data = in_data[idx];
        sel_last = in_last[idx];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lock_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (|acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= idx;
            // a multi-beat first beat locks the port; its last beat releases it
            if (state == IDLE && !sel_last) begin
                state    <= LOCKED;
                lock_idx <= idx;
            end else if (state == LOCKED && sel_last) begin
                state <= IDLE;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
    a_grant_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(arb_grant));
    a_trigger_one:   assert property (@(posedge clock) disable iff (reset) arb_trigger |-> $onehot(in_ready));
    a_ready_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(in_ready));
endmodule

// File: tb/tb_rr_burst_mux.sv
// tb_rr_burst_mux: directed checks of rr_burst_mux against a small round-robin arbiter stub.
module tb_rr_burst_mux;
    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       in_valid, in_ready, in_last, arb_request, arb_grant;
    logic [3:0][7:0]  in_data;
    logic             arb_trigger, out_valid, out_ready, out_last;
    logic [7:0]       out_data;
    logic [1:0]       out_src, ptr;
    int               total = 0, bad = 0;

    rr_burst_mux #(.nReq(4), .W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .arb_request(arb_request),
        .arb_grant(arb_grant), .arb_trigger(arb_trigger), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_src(out_src)
    );

    always #5 clock = ~clock;

    // arbiter stub: first requester at or after ptr; trigger moves ptr past the winner
    function automatic logic [3:0] rr(input logic [3:0] r, input logic [1:0] p);
        logic [3:0] g = '0;
        logic [1:0] q;
        for (int k = 0; k < 4; k++) begin
            q = p + 2'(k);
            if (g == 0 && r[q]) g[q] = 1'b1;
        end
        return g;
    endfunction
    assign arb_grant = rr(arb_request, ptr);
    always @(posedge clock) begin
        if (reset) ptr <= 2'd0;
        else if (arb_trigger)
            for (int k = 0; k < 4; k++)
                if (arb_grant[k]) ptr <= 2'(k + 1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic out_is(input string tag, input logic [7:0] d, input logic [1:0] s, input logic l);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_src"}, 32'(out_src), 32'(s));
        check({tag, "_last"}, 32'(out_last), 32'(l));
    endtask

    initial begin
        reset = 1; in_valid = 4'hF; in_last = 4'hF; in_data = '0; out_ready = 1;
        // 1. reset
        for (int c = 0; c < 2; c++) begin
            tick;
            check("rst_ready", 32'(in_ready), 0);
            check("rst_trig", 32'(arb_trigger), 0);
            check("rst_oval", 32'(out_valid), 0);
        end
        reset = 0; in_valid = 4'b1000; in_data[3] = 8'h33; settle;
        check("rel_ready", 32'(in_ready), 32'h8);
        check("rel_trig", 32'(arb_trigger), 1);
        tick;
        out_is("rel_out", 8'h33, 2'd3, 1'b1);
        // 2. single-beat round robin
        in_valid = 4'hF; in_last = 4'hF;
        for (int i = 0; i < 4; i++) in_data[i] = 8'(i);
        settle;
        for (int j = 0; j < 5; j++) begin
            check("rr_trig", 32'(arb_trigger), 1);
            check("rr_ready", 32'(in_ready), 32'(1 << (j % 4)));
            tick;
            out_is("rr_out", 8'(j % 4), 2'(j % 4), 1'b1);
        end
        // 3. burst lock on port1 while port2 waits
        in_valid = 4'b0110; in_last = 4'b0100; in_data[1] = 8'hA1; in_data[2] = 8'hB0; settle;
        check("bl_trig1", 32'(arb_trigger), 1);
        check("bl_ready1", 32'(in_ready), 32'h2);
        tick;
        out_is("bl_a1", 8'hA1, 2'd1, 1'b0);
        in_data[1] = 8'hA2; settle;
        check("bl_trig2", 32'(arb_trigger), 0);
        check("bl_ready2", 32'(in_ready), 32'h2);
        check("bl_req", 32'(arb_request), 0);
        tick;
        out_is("bl_a2", 8'hA2, 2'd1, 1'b0);
        in_data[1] = 8'hA3; in_last = 4'b0110; settle;
        check("bl_trig3", 32'(arb_trigger), 0);
        check("bl_ready3", 32'(in_ready), 32'h2);
        tick;
        out_is("bl_a3", 8'hA3, 2'd1, 1'b1);
        in_valid = 4'b0100; settle;
        check("bl_trig4", 32'(arb_trigger), 1);
        check("bl_ready4", 32'(in_ready), 32'h4);
        tick;
        out_is("bl_b0", 8'hB0, 2'd2, 1'b1);
        // 4. back-pressure
        in_valid = 4'b1000; in_last = 4'hF; in_data[3] = 8'h5A; settle;
        check("bp_trig", 32'(arb_trigger), 1);
        tick;
        out_is("bp_load", 8'h5A, 2'd3, 1'b1);
        out_ready = 0; in_data[3] = 8'h6B;
        for (int c = 0; c < 3; c++) begin
            settle;
            check("bp_ready", 32'(in_ready), 0);
            check("bp_trig0", 32'(arb_trigger), 0);
            out_is("bp_hold", 8'h5A, 2'd3, 1'b1);
            tick;
        end
        out_ready = 1; settle;
        check("bp_resume_ready", 32'(in_ready), 32'h8);
        check("bp_resume_data", 32'(out_data), 32'h5A);
        tick;
        out_is("bp_next", 8'h6B, 2'd3, 1'b1);
        in_valid = 0; tick;
        check("bp_drain", 32'(out_valid), 0);
        // 5. bubble inside port0 burst while port3 waits
        in_valid = 4'b1001; in_last = 4'b1000; in_data[0] = 8'hC1; in_data[3] = 8'hD1; settle;
        check("bu_trig", 32'(arb_trigger), 1);
        check("bu_ready", 32'(in_ready), 32'h1);
        tick;
        out_is("bu_c1", 8'hC1, 2'd0, 1'b0);
        in_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            settle;
            check("bu_p3_ready", 32'(in_ready[3]), 0);
            check("bu_trig0", 32'(arb_trigger), 0);
            check("bu_req", 32'(arb_request), 0);
            tick;
            check("bu_bubble", 32'(out_valid), 0);
        end
        in_valid = 4'b1001; in_last = 4'b1001; in_data[0] = 8'hC2; settle;
        check("bu_ready2", 32'(in_ready), 32'h1);
        tick;
        out_is("bu_c2", 8'hC2, 2'd0, 1'b1);
        in_valid = 4'b1000; settle;
        check("bu_p3_trig", 32'(arb_trigger), 1);
        check("bu_p3_ready2", 32'(in_ready), 32'h8);
        tick;
        out_is("bu_d1", 8'hD1, 2'd3, 1'b1);
        // 6. reset mid-burst on port2
        in_valid = 4'b0100; in_last = 4'b0000; in_data[2] = 8'hE1; settle;
        check("rm_trig", 32'(arb_trigger), 1);
        tick;
        out_is("rm_e1", 8'hE1, 2'd2, 1'b0);
        in_data[2] = 8'hE2; tick;
        out_is("rm_e2", 8'hE2, 2'd2, 1'b0);
        reset = 1; in_data[2] = 8'hE3; settle;
        check("rm_ready", 32'(in_ready), 0);
        check("rm_trig0", 32'(arb_trigger), 0);
        tick;
        check("rm_oval", 32'(out_valid), 0);
        reset = 0; in_valid = 4'b0010; in_last = 4'b0010; in_data[1] = 8'hF1; settle;
        check("rm_req_idle", 32'(arb_request), 32'h2);
        check("rm_ready2", 32'(in_ready), 32'h2);
        check("rm_trig2", 32'(arb_trigger), 1);
        tick;
        out_is("rm_f1", 8'hF1, 2'd1, 1'b1);
        in_valid = 0; tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
